key_freq_ctrl: RTL and testbench

- Front-panel control stage directly upstream of the breathing-LED PWM block.
- Turns three raw active-low push-buttons into the LED block's control inputs: on/off switch, step-update strobe and 10-bit frequency step.
- Per button: synchronise, debounce, then detect presses with auto-repeat on hold.
- Keeps the step value saturated to [STEP_MIN, STEP_MAX] and strobes set_en on every change.

---
 rtl/key_ctrl_pkg.sv | 15 +
 rtl/key_debounce.sv | 114 +++++++++++
 rtl/key_freq_ctrl.sv | 75 +++++++
 tb/tb_key_freq_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/key_ctrl_pkg.sv
// Shared types and default timing for the front-panel key controller.
package key_ctrl_pkg;

   localparam int unsigned STEP_W            = 10;
   localparam int unsigned DEBOUNCE_DEF      = 1000000;
   localparam int unsigned REPEAT_DELAY_DEF  = 25000000;
   localparam int unsigned REPEAT_PERIOD_DEF = 10000000;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      RPT
   } key_state_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser, debounce counter and press/auto-repeat FSM.
module key_debounce
   import key_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
   parameter bit          REPEAT_EN       = 1'b1
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key_n,
   output logic press_evt
);

   localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   logic [1:0]       sync_q;
   logic [DB_W-1:0]  db_cnt;
   logic             key_lvl;
   logic             key_lvl_d;
   logic             armed;
   logic             press_fall;
   key_state_e       state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             evt_d;

   // Synchroniser resets to "pressed" so a key held through reset never arms early
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) sync_q <= 2'b00;
      else            sync_q <= {sync_q[0], key_n};
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         db_cnt    <= '0;
         key_lvl   <= 1'b1;
         key_lvl_d <= 1'b1;
         armed     <= 1'b0;
      end else begin
         key_lvl_d <= key_lvl;
         armed     <= armed | (key_lvl & sync_q[1]);
         if (sync_q[1] == key_lvl) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            key_lvl <= sync_q[1];
            db_cnt  <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   assign press_fall = key_lvl_d & ~key_lvl & armed;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         press_evt <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         press_evt <= evt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      evt_d   = 1'b0;
      case (state_q)
         IDLE: begin
            tmr_d = '0;
            if (press_fall) begin
               evt_d   = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (key_lvl) begin
               state_d = IDLE;
               tmr_d   = '0;
            end else if (REPEAT_EN) begin
               if (tmr_q == TMR_W'(REPEAT_DELAY - 1)) begin
                  state_d = RPT;
                  evt_d   = 1'b1;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_q + TMR_W'(1);
               end
            end
         end
         RPT: begin
            if (key_lvl) begin
               state_d = IDLE;
               tmr_d   = '0;
            end else if (tmr_q == TMR_W'(REPEAT_PERIOD - 1)) begin
               evt_d = 1'b1;
               tmr_d = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/key_freq_ctrl.sv
// Front-panel control for the breathing LED: on/off toggle and saturated frequency step.
module key_freq_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
   parameter int unsigned STEP_MIN        = 1,
   parameter int unsigned STEP_MAX        = 10,
   parameter int unsigned STEP_INIT       = 1,
   parameter bit          SW_INIT         = 1'b1
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              key_up_n,
   input  logic              key_dn_n,
   input  logic              key_sw_n,
   output logic              sw_ctrl,
   output logic              set_en,
   output logic [STEP_W-1:0] set_freq_step,
   output logic              at_limit
);

   localparam logic [STEP_W-1:0] MIN_V    = STEP_W'(STEP_MIN);
   localparam logic [STEP_W-1:0] MAX_V    = STEP_W'(STEP_MAX);
   localparam logic [STEP_W-1:0] INIT_V   = STEP_W'(STEP_INIT);
   localparam logic              LIM_INIT = (STEP_INIT == STEP_MIN) || (STEP_INIT == STEP_MAX);

   logic              up_evt, dn_evt, sw_evt;
   logic              init_q;
   logic              strobe_d;
   logic [STEP_W-1:0] step_d;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                  .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
      u_key_up (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_up_n), .press_evt(up_evt));

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                  .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1))
      u_key_dn (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_dn_n), .press_evt(dn_evt));

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                  .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0))
      u_key_sw (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_sw_n), .press_evt(sw_evt));

   // Simultaneous up and down cancel; init_q forces one strobe after reset
   always_comb begin
      step_d   = set_freq_step;
      strobe_d = init_q;
      if (up_evt && !dn_evt && (set_freq_step < MAX_V)) begin
         step_d   = set_freq_step + STEP_W'(1);
         strobe_d = 1'b1;
      end else if (dn_evt && !up_evt && (set_freq_step > MIN_V)) begin
         step_d   = set_freq_step - STEP_W'(1);
         strobe_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         init_q        <= 1'b1;
         sw_ctrl       <= SW_INIT;
         set_en        <= 1'b0;
         set_freq_step <= INIT_V;
         at_limit      <= LIM_INIT;
      end else begin
         init_q        <= 1'b0;
         set_en        <= strobe_d;
         set_freq_step <= step_d;
         at_limit      <= (step_d == MIN_V) || (step_d == MAX_V);
         if (sw_evt) sw_ctrl <= ~sw_ctrl;
      end
   end

endmodule

// File: tb/tb_key_freq_ctrl.sv
// Self-checking bench for key_freq_ctrl with short debounce/repeat timing.
module tb_key_freq_ctrl;

   localparam int DB   = 8;
   localparam int RD   = 40;
   localparam int RP   = 10;
   localparam int SMIN = 1;
   localparam int SMAX = 10;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       key_up_n  = 1'b1;
   logic       key_dn_n  = 1'b1;
   logic       key_sw_n  = 1'b1;
   logic       sw_ctrl, set_en, at_limit;
   logic [9:0] set_freq_step;

   key_freq_ctrl #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
      .STEP_MIN(SMIN), .STEP_MAX(SMAX), .STEP_INIT(1), .SW_INIT(1'b1)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .key_up_n(key_up_n), .key_dn_n(key_dn_n), .key_sw_n(key_sw_n),
      .sw_ctrl(sw_ctrl), .set_en(set_en), .set_freq_step(set_freq_step), .at_limit(at_limit)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      bit up;
      bit dn;
      bit sw;
      int hold;
      int exp_step;
      bit exp_sw;
      bit exp_lim;
   } vec_t;

   vec_t vecs[16];
   int   tests = 0;
   int   fails = 0;
   int   exp_q[$];
   int   m_step = 1;
   bit   m_sw = 1'b1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle advance samples the strobe and pops the scoreboard
   task automatic tick();
      @(negedge sys_clk);
      if (sys_rst_n && set_en) begin
         if (exp_q.size() == 0) check("unexpected_strobe", int'(set_freq_step), -1);
         else                   check("strobe_step", int'(set_freq_step), exp_q.pop_front());
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) tick();
   endtask

   task automatic apply(input vec_t v, input int idx);
      key_up_n = !v.up;
      key_dn_n = !v.dn;
      key_sw_n = !v.sw;
      if (v.hold >= DB) begin
         if (v.up && !v.dn && m_step < SMAX) begin m_step++; exp_q.push_back(m_step); end
         if (v.dn && !v.up && m_step > SMIN) begin m_step--; exp_q.push_back(m_step); end
         if (v.sw) m_sw = !m_sw;
      end
      wait_n(v.hold);
      key_up_n = 1'b1;
      key_dn_n = 1'b1;
      key_sw_n = 1'b1;
      wait_n(40);
      check($sformatf("vec%0d_step", idx), int'(set_freq_step), v.exp_step);
      check($sformatf("vec%0d_sw", idx), int'(sw_ctrl), int'(v.exp_sw));
      check($sformatf("vec%0d_lim", idx), int'(at_limit), int'(v.exp_lim));
      check($sformatf("vec%0d_pending", idx), exp_q.size(), 0);
   endtask

   initial begin
      int lat;
      bit found;

      vecs[0]  = '{1'b0, 1'b1, 1'b0, 20, 1, 1'b1, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 1'b0,  5, 1, 1'b1, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 1'b0,  5, 1, 1'b1, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 1'b0,  5, 1, 1'b1, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 20, 2, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 20, 3, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 20, 4, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 20, 5, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 20, 5, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 20, 4, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 20, 3, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 20, 2, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 20, 2, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 20, 2, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 20, 1, 1'b1, 1'b1};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 20, 1, 1'b1, 1'b1};

      // Reset values and the single post-reset strobe
      wait_n(3);
      check("rst_set_en", int'(set_en), 0);
      check("rst_step", int'(set_freq_step), 1);
      check("rst_sw", int'(sw_ctrl), 1);
      check("rst_lim", int'(at_limit), 1);
      exp_q.push_back(1);
      sys_rst_n = 1'b1;
      tick();
      check("post_rst_strobe", exp_q.size(), 0);
      wait_n(20);

      // Raw edge to strobe latency
      key_up_n = 1'b0;
      m_step = 2;
      exp_q.push_back(2);
      lat = 0;
      found = 1'b0;
      for (int i = 1; i <= 50 && !found; i++) begin
         tick();
         if (set_en) begin lat = i; found = 1'b1; end
      end
      check("latency", lat, DB + 4);
      check("lat_step", int'(set_freq_step), 2);
      check("lat_lim", int'(at_limit), 0);
      wait_n(8);
      key_up_n = 1'b1;
      wait_n(40);
      check("lat_pending", exp_q.size(), 0);

      for (int i = 0; i < 16; i++) apply(vecs[i], i);

      // Long hold: auto-repeat walks the step up to the ceiling
      key_up_n = 1'b0;
      for (int s = 2; s <= SMAX; s++) exp_q.push_back(s);
      m_step = SMAX;
      wait_n(200);
      check("rpt_step", int'(set_freq_step), SMAX);
      check("rpt_lim", int'(at_limit), 1);
      check("rpt_pending", exp_q.size(), 0);
      key_up_n = 1'b1;
      wait_n(40);

      // Up at the ceiling must not strobe
      key_up_n = 1'b0;
      wait_n(20);
      key_up_n = 1'b1;
      wait_n(40);
      check("max_step", int'(set_freq_step), SMAX);

      // Reset while in HOLD with the key still held
      key_up_n = 1'b0;
      wait_n(30);
      sys_rst_n = 1'b0;
      wait_n(3);
      check("midrst_step", int'(set_freq_step), 1);
      check("midrst_set_en", int'(set_en), 0);
      m_step = 1;
      exp_q.push_back(1);
      sys_rst_n = 1'b1;
      wait_n(100);
      check("held_step", int'(set_freq_step), 1);
      check("held_pending", exp_q.size(), 0);
      key_up_n = 1'b1;
      wait_n(40);
      key_up_n = 1'b0;
      exp_q.push_back(2);
      wait_n(20);
      key_up_n = 1'b1;
      wait_n(40);
      check("repress_step", int'(set_freq_step), 2);
      check("repress_pending", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
